hb_master_arbiter: RTL

Round-robin arbiter that shares the XT_HB high-speed bus between up to `MASTER_NUM` masters, for example the RISC-V core data port and a future DMA engine. It sits between the masters' request lines and the XT_HB mux. It owns a registered grant, holds that grant until the granted transfer completes (`slave_wait_finish`), and supports a bounded bus lock so a master can run back-to-back transfers. XT_HB uses the registered grant to steer addresses and data.

---
 rtl/hb_master_arbiter_if.sv | 37 +++
 rtl/hb_master_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/hb_master_arbiter_if.sv
// Bus-side signal bundle between the XT_HB masters and the master arbiter.
//
// Signals:
//   master_req        per-master request (read or write pending)
//   master_lock       per-master request to keep the grant after the current transfer
//   slave_wait_finish addressed slave completes the transfer this cycle
//   grant             registered one-hot owner, zero when idle
//   grant_id          registered binary owner index, zero when idle
//   bus_busy          registered OR of grant
//   master_accept     combinational per-master transfer-complete strobe
//
// Modports:
//   slave  - the arbiter's view (takes requests, drives grants)
//   master - the requesters' / bus view (drives requests, sees grants)
interface hb_master_arbiter_if #(
  parameter int MASTER_NUM = 2
);
  localparam int ID_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  logic [MASTER_NUM-1:0] master_req;
  logic [MASTER_NUM-1:0] master_lock;
  logic                  slave_wait_finish;
  logic [MASTER_NUM-1:0] grant;
  logic [ID_W-1:0]       grant_id;
  logic                  bus_busy;
  logic [MASTER_NUM-1:0] master_accept;

  modport slave (
    input  master_req, master_lock, slave_wait_finish,
    output grant, grant_id, bus_busy, master_accept
  );

  modport master (
    output master_req, master_lock, slave_wait_finish,
    input  grant, grant_id, bus_busy, master_accept
  );
endinterface

// File: rtl/hb_master_arbiter.sv
// Round-robin arbiter sharing the XT_HB bus between MASTER_NUM masters.
// The grant is registered and held until the owner's transfer completes;
// a locking owner may keep the bus for up to HOLD_MAX consecutive transfers
// while others are waiting (indefinitely when nobody else is requesting).
//
// Ports:
//   hb_clk  bus clock
//   rst_n   asynchronous active-low reset
//   bus     hb_master_arbiter_if.slave: requests, locks and slave completion
//           in; grant, grant_id, bus_busy and master_accept out
module hb_master_arbiter #(
  parameter int MASTER_NUM = 2,
  parameter int HOLD_MAX   = 4
) (
  input logic                  hb_clk,
  input logic                  rst_n,
  hb_master_arbiter_if.slave   bus
);
  localparam int ID_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state;
  logic [ID_W-1:0] last_id;
  logic [3:0]      hold_cnt;

  logic            found;
  logic [ID_W-1:0] win_id;
  logic            owner_req;
  logic            owner_lock;
  logic            owner_done;
  logic            any_other;
  logic            keep;

  // The search always starts just after last_id. While a master owns the
  // bus last_id equals the owner, so the owner comes last in the order and
  // is only picked again when no other master is requesting.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int off = 1; off <= MASTER_NUM; off++) begin
      if (!found && bus.master_req[(int'(last_id) + off) % MASTER_NUM]) begin
        found  = 1'b1;
        win_id = ID_W'((int'(last_id) + off) % MASTER_NUM);
      end
    end
  end

  assign owner_req  = |(bus.grant & bus.master_req);
  assign owner_lock = |(bus.grant & bus.master_lock);
  assign owner_done = owner_req & bus.slave_wait_finish;
  assign any_other  = |(bus.master_req & ~bus.grant);
  assign keep       = owner_lock & (((int'(hold_cnt) + 1) < HOLD_MAX) | ~any_other);

  assign bus.master_accept = bus.grant & bus.master_req & {MASTER_NUM{bus.slave_wait_finish}};

  // Ownership FSM. A release (completion without keep, or abort) hands the
  // bus straight to the next winner at the same edge, avoiding an idle cycle.
  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.bus_busy <= 1'b0;
      last_id      <= ID_W'(MASTER_NUM - 1);
      hold_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state        <= OWNED;
            bus.grant    <= MASTER_NUM'(1) << win_id;
            bus.grant_id <= win_id;
            bus.bus_busy <= 1'b1;
            last_id      <= win_id;
            hold_cnt     <= '0;
          end
        end
        OWNED: begin
          if (owner_done && keep) begin
            hold_cnt <= (hold_cnt == 4'd15) ? 4'd15 : hold_cnt + 4'd1;
          end else if (owner_done || !owner_req) begin
            if (found) begin
              bus.grant    <= MASTER_NUM'(1) << win_id;
              bus.grant_id <= win_id;
              bus.bus_busy <= 1'b1;
              last_id      <= win_id;
              hold_cnt     <= '0;
            end else begin
              state        <= IDLE;
              bus.grant    <= '0;
              bus.grant_id <= '0;
              bus.bus_busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
